// File: rtl/qoa_pkg.sv
// Shared QOA definitions for the slice encoder and decoder.
// Holds the format constants, the state encoding and the codec lookup tables.
package qoa_pkg;

   localparam int SLICE_LEN = 20;
   localparam int SLICE_W   = 64;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_EMIT    = 2'd2
   } qoa_state_e;

   function automatic logic [16:0] recip_lut(input logic [3:0] sf);
      logic [16:0] r;
      case (sf)
         4'd0:    r = 17'd65536;
         4'd1:    r = 17'd9363;
         4'd2:    r = 17'd3121;
         4'd3:    r = 17'd1457;
         4'd4:    r = 17'd781;
         4'd5:    r = 17'd475;
         4'd6:    r = 17'd311;
         4'd7:    r = 17'd216;
         4'd8:    r = 17'd156;
         4'd9:    r = 17'd117;
         4'd10:   r = 17'd90;
         4'd11:   r = 17'd71;
         4'd12:   r = 17'd57;
         4'd13:   r = 17'd47;
         4'd14:   r = 17'd39;
         4'd15:   r = 17'd32;
         default: r = 17'd65536;
      endcase
      return r;
   endfunction

   // Index is the clamped quantized value plus 8 (0..16).
   function automatic logic [2:0] quant_lut(input logic [4:0] idx);
      logic [2:0] c;
      case (idx)
         5'd0, 5'd1, 5'd2:   c = 3'd7;
         5'd3, 5'd4:         c = 3'd5;
         5'd5, 5'd6:         c = 3'd3;
         5'd7:               c = 3'd1;
         5'd8, 5'd9:         c = 3'd0;
         5'd10, 5'd11:       c = 3'd2;
         5'd12, 5'd13:       c = 3'd4;
         5'd14, 5'd15, 5'd16: c = 3'd6;
         default:            c = 3'd0;
      endcase
      return c;
   endfunction

   function automatic logic [11:0] scalefactor_lut(input logic [3:0] sf);
      logic [11:0] s;
      case (sf)
         4'd0:    s = 12'd1;
         4'd1:    s = 12'd7;
         4'd2:    s = 12'd21;
         4'd3:    s = 12'd45;
         4'd4:    s = 12'd84;
         4'd5:    s = 12'd138;
         4'd6:    s = 12'd211;
         4'd7:    s = 12'd304;
         4'd8:    s = 12'd421;
         4'd9:    s = 12'd562;
         4'd10:   s = 12'd731;
         4'd11:   s = 12'd928;
         4'd12:   s = 12'd1157;
         4'd13:   s = 12'd1419;
         4'd14:   s = 12'd1715;
         4'd15:   s = 12'd2048;
         default: s = 12'd1;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/qoa_quantize.sv
// Combinational QOA residual quantizer, bit-exact to the reference encoder.
module qoa_quantize (
   input  logic [3:0]  sf,
   input  logic [16:0] v,
   output logic [2:0]  code
);
   import qoa_pkg::*;

   logic signed [35:0] v_ext_s;
   logic signed [35:0] r_ext_s;
   logic signed [35:0] prod_s;
   logic signed [19:0] n_s;
   logic signed [19:0] adj_s;
   logic signed [19:0] clamp_s;
   logic signed [1:0]  sgn_v_s;
   logic signed [1:0]  sgn_n_s;
   logic [4:0]         idx_s;

   // Scale by the reciprocal, round, nudge toward the residual's sign, clamp, map to code.
   always_comb begin
      v_ext_s = {{19{v[16]}}, v};
      r_ext_s = {19'd0, recip_lut(sf)};
      prod_s  = v_ext_s * r_ext_s;
      n_s     = 20'((prod_s + 36'sd32768) >>> 16);
      if (v[16]) begin
         sgn_v_s = -2'sd1;
      end else if (v != 17'd0) begin
         sgn_v_s = 2'sd1;
      end else begin
         sgn_v_s = 2'sd0;
      end
      if (n_s < 20'sd0) begin
         sgn_n_s = -2'sd1;
      end else if (n_s > 20'sd0) begin
         sgn_n_s = 2'sd1;
      end else begin
         sgn_n_s = 2'sd0;
      end
      adj_s = n_s + {{18{sgn_v_s[1]}}, sgn_v_s} - {{18{sgn_n_s[1]}}, sgn_n_s};
      if (adj_s > 20'sd8) begin
         clamp_s = 20'sd8;
      end else if (adj_s < -20'sd8) begin
         clamp_s = -20'sd8;
      end else begin
         clamp_s = adj_s;
      end
      idx_s = clamp_s[4:0] + 5'd8;
      code  = quant_lut(idx_s);
   end

endmodule

// File: rtl/qoa_slice_encoder.sv
// Packs 20 quantized residuals plus a scale-factor nibble into a 64-bit QOA slice
// and streams it out MSB-first as 8 bytes over a valid/ready interface.
module qoa_slice_encoder #(
   parameter int SLICE_LEN = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  sf_in,
   input  logic [16:0] res_in,
   input  logic        res_valid,
   output logic        res_ready,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   input  logic        byte_ready,
   output logic        busy
);
   import qoa_pkg::*;

   qoa_state_e         state_r;
   logic [SLICE_W-1:0] slice_r;
   logic [4:0]         res_cnt_r;
   logic [2:0]         byte_cnt_r;
   logic [3:0]         sf_r;
   logic [2:0]         code_s;
   logic [5:0]         shamt_s;

   qoa_quantize u_quant (
      .sf   (sf_r),
      .v    (res_in),
      .code (code_s)
   );

   // Code k lands at bits [59-3k : 57-3k]; shift amount is 57 - 3k.
   always_comb begin
      shamt_s = 6'd57 - ({1'b0, res_cnt_r} + {res_cnt_r, 1'b0});
   end

   // Slice FSM; in EMIT the slice register shifts left so the next byte is always [55:48].
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         slice_r    <= '0;
         res_cnt_r  <= 5'd0;
         byte_cnt_r <= 3'd0;
         sf_r       <= 4'd0;
         res_ready  <= 1'b0;
         byte_valid <= 1'b0;
         byte_out   <= 8'd0;
         busy       <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_r   <= ST_COLLECT;
                  sf_r      <= sf_in;
                  slice_r   <= {sf_in, 60'd0};
                  res_cnt_r <= 5'd0;
                  res_ready <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            ST_COLLECT: begin
               if (res_valid && res_ready) begin
                  slice_r <= slice_r | ({61'd0, code_s} << shamt_s);
                  if (res_cnt_r == 5'(SLICE_LEN - 1)) begin
                     state_r    <= ST_EMIT;
                     res_ready  <= 1'b0;
                     byte_valid <= 1'b1;
                     byte_out   <= slice_r[63:56];
                     byte_cnt_r <= 3'd0;
                  end else begin
                     res_cnt_r <= res_cnt_r + 5'd1;
                  end
               end
            end
            ST_EMIT: begin
               if (byte_valid && byte_ready) begin
                  if (byte_cnt_r == 3'd7) begin
                     state_r    <= ST_IDLE;
                     byte_valid <= 1'b0;
                     byte_out   <= 8'd0;
                     busy       <= 1'b0;
                     slice_r    <= '0;
                  end else begin
                     byte_cnt_r <= byte_cnt_r + 3'd1;
                     byte_out   <= slice_r[55:48];
                     slice_r    <= {slice_r[55:0], 8'd0};
                  end
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               res_ready  <= 1'b0;
               byte_valid <= 1'b0;
               byte_out   <= 8'd0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_qoa_slice_encoder.sv
// Self-checking bench for qoa_slice_encoder: directed slice table, randomized slices
// against an arithmetic reference model, stall, ignored-start and mid-slice reset cases.
module tb_qoa_slice_encoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  sf_in = 4'd0;
   logic [16:0] res_in = 17'd0;
   logic        res_valid = 1'b0;
   logic        res_ready;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        byte_ready = 1'b0;
   logic        busy;

   qoa_slice_encoder dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .sf_in      (sf_in),
      .res_in     (res_in),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int hs_cnt = 0;
   int recip_t [16] = '{65536, 9363, 3121, 1457, 781, 475, 311, 216,
                        156, 117, 90, 71, 57, 47, 39, 32};
   int quant_t [17] = '{7, 7, 7, 5, 5, 3, 3, 1, 0, 0, 2, 2, 4, 4, 6, 6, 6};
   int res_a [20];
   logic [63:0] got64;
   int cycles;

   typedef struct {
      logic [3:0]  sf;
      int          r0;
      int          r1;
      logic [63:0] exp;
      bit          randv;
      int          stall_at;
      int          glitch_at;
   } vec_t;

   vec_t vecs [5];

   always @(posedge clk) begin
      if (byte_valid && byte_ready) hs_cnt <= hs_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int sgn(input longint x);
      if (x > 0) return 1;
      else if (x < 0) return -1;
      else return 0;
   endfunction

   function automatic int q_ref(input int sf, input int v);
      longint p;
      longint n;
      p = longint'(v) * longint'(recip_t[sf]);
      n = (p + 64'sd32768) >>> 16;
      n = n + sgn(longint'(v)) - sgn(n);
      if (n > 8) n = 8;
      if (n < -8) n = -8;
      return quant_t[int'(n) + 8];
   endfunction

   function automatic logic [63:0] slice_ref(input int sf);
      logic [63:0] s;
      s = 64'(sf);
      for (int k = 0; k < 20; k++) s = (s << 3) | 64'(q_ref(sf, res_a[k]));
      return s;
   endfunction

   task automatic run_slice(input int sf, input bit randv, input int stall_at,
                            input int glitch_at, input string tag);
      int k;
      int j;
      int guard;
      bit acc;
      bit stalled;
      bit glitched;
      logic [7:0] b;
      logic [7:0] held;
      stalled = 1'b0;
      glitched = 1'b0;
      @(negedge clk);
      start = 1'b1;
      sf_in = 4'(sf);
      @(negedge clk);
      start = 1'b0;
      sf_in = 4'($urandom);
      chk({tag, " collect_entry"}, 64'({busy, res_ready, byte_valid}), 64'b110);
      k = 0; guard = 0; cycles = 0; got64 = 64'd0;
      while (k < 20 && guard < 2000) begin
         res_valid = randv ? 1'($urandom_range(0, 1)) : 1'b1;
         res_in = 17'(res_a[k]);
         if (k == glitch_at && !glitched) begin
            glitched = 1'b1;
            start = 1'b1;
            sf_in = 4'd3;
         end
         acc = res_valid && res_ready;
         @(negedge clk);
         start = 1'b0;
         if (acc) k++;
         guard++; cycles++;
      end
      res_valid = 1'b0;
      chk({tag, " residuals_accepted"}, 64'(k), 64'd20);
      chk({tag, " emit_entry"}, 64'({res_ready, byte_valid, busy}), 64'b011);
      j = 0; guard = 0;
      while (j < 8 && guard < 2000) begin
         if (j == stall_at && !stalled) begin
            stalled = 1'b1;
            byte_ready = 1'b0;
            held = byte_out;
            for (int s = 0; s < 5; s++) begin
               @(negedge clk);
               chk({tag, " stall_hold"}, 64'({byte_valid, byte_out}), 64'({1'b1, held}));
            end
         end
         byte_ready = 1'b1;
         acc = byte_valid && byte_ready;
         b = byte_out;
         @(negedge clk);
         if (acc) begin
            got64 = {got64[55:0], b};
            j++;
         end
         guard++; cycles++;
      end
      byte_ready = 1'b0;
      chk({tag, " bytes_emitted"}, 64'(j), 64'd8);
      chk({tag, " back_to_idle"}, 64'({busy, byte_valid, res_ready}), 64'b000);
   endtask

   initial begin
      logic [63:0] g1;
      logic [16:0] t;
      int sf;
      int h0;

      vecs[0] = '{4'd0,  0,    0,    64'h0000_0000_0000_0000, 1'b0, -1, -1};
      vecs[1] = '{4'd0,  3,    -20,  64'h05C0_0000_0000_0000, 1'b0, -1, -1};
      vecs[2] = '{4'd15, 5000, 1000, 64'hF400_0000_0000_0000, 1'b0, -1, -1};
      vecs[3] = '{4'd0,  3,    -20,  64'h05C0_0000_0000_0000, 1'b1, 3,  -1};
      vecs[4] = '{4'd0,  3,    -20,  64'h05C0_0000_0000_0000, 1'b0, -1, 5};

      repeat (3) @(negedge clk);
      chk("reset_outputs", 64'({res_ready, byte_valid, busy, byte_out}), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         for (int k = 0; k < 20; k++) res_a[k] = 0;
         res_a[0] = vecs[i].r0;
         res_a[1] = vecs[i].r1;
         run_slice(int'(vecs[i].sf), vecs[i].randv, vecs[i].stall_at, vecs[i].glitch_at,
                   $sformatf("vec%0d", i));
         chk($sformatf("vec%0d slice", i), got64, vecs[i].exp);
         if (!vecs[i].randv && vecs[i].stall_at < 0)
            chk($sformatf("vec%0d cycles", i), 64'(cycles), 64'd28);
      end

      for (int it = 0; it < 6; it++) begin
         sf = int'($urandom_range(0, 15));
         for (int k = 0; k < 20; k++) begin
            t = 17'($urandom);
            if ((it % 2) == 1) t = 17'(int'($urandom_range(0, 600)) - 300);
            res_a[k] = int'($signed(t));
         end
         run_slice(sf, 1'b0, -1, -1, $sformatf("rnd%0d", it));
         g1 = got64;
         chk($sformatf("rnd%0d model", it), g1, slice_ref(sf));
         run_slice(sf, 1'b1, int'($urandom_range(0, 7)), -1, $sformatf("rnd%0d_stall", it));
         chk($sformatf("rnd%0d stall_model", it), got64, slice_ref(sf));
         chk($sformatf("rnd%0d stall_vs_free", it), got64, g1);
      end

      h0 = hs_cnt;
      @(negedge clk);
      start = 1'b1;
      sf_in = 4'd7;
      @(negedge clk);
      start = 1'b0;
      res_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         res_in = 17'($urandom);
         @(negedge clk);
      end
      res_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midreset_outputs", 64'({res_ready, byte_valid, busy, byte_out}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("midreset_quiet", 64'({byte_valid, busy}), 64'd0);
      sf = int'($urandom_range(0, 15));
      for (int k = 0; k < 20; k++) begin
         t = 17'($urandom);
         res_a[k] = int'($signed(t));
      end
      run_slice(sf, 1'b1, 6, -1, "fresh");
      chk("fresh model", got64, slice_ref(sf));
      chk("fresh handshakes", 64'(hs_cnt - h0), 64'd8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/qoa_slice_encoder.md
# qoa_slice_encoder

Encoder-side counterpart to the QOA slice decoder: quantizes a stream of 20 signed prediction residuals against one scale factor and packs them into a standard 64-bit QOA slice. The slice is emitted as 8 bytes, MSB first, over a valid/ready byte stream. The block sits between the encoder's LMS predictor, which supplies residuals, and the byte output path toward the pins.

## Interface
Parameters:
- SLICE_LEN, 20: residuals per slice; fixed by the QOA format, not to be overridden.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- start  in  1  one-cycle pulse that begins a slice; honored only in IDLE.
- sf_in  in  4  scale-factor index 0..15; latched on start.
- res_in  in  17  signed two's-complement residual (sample minus prediction).
- res_valid  in  1  res_in is valid.
- res_ready  out  1  block accepts a residual this cycle.
- byte_out  out  8  slice byte.
- byte_valid  out  1  byte_out is valid.
- byte_ready  in  1  downstream accepts byte_out.
- busy  out  1  high in every state except IDLE.

## Operation
- State machine: IDLE -> COLLECT (on start) -> EMIT (after the 20th residual is accepted) -> IDLE (after byte 7 is accepted).
- On start: latch sf, set slice[63:60] = sf, clear the residual count.
- COLLECT: each accepted residual v (res_valid & res_ready) is quantized combinationally and the 3-bit code is written to slice bits [59-3k : 57-3k], where k = 0..19 is the residual count.
- Quantization, which must be bit-exact to the QOA reference encoder:
  - r = RECIP[sf]; n = (v*r + 32768) >>> 16, arithmetic shift on a signed product of at least 34 bits.
  - n = n + sgn(v) - sgn(n).
  - Clamp n to -8..8, then code = QUANT[n+8].
- Constants:
  - RECIP = 65536,9363,3121,1457,781,475,311,216,156,117,90,71,57,47,39,32.
  - QUANT = 7,7,7,5,5,3,3,1,0,0,2,2,4,4,6,6,6.
- EMIT: byte i (i = 0..7) = slice[63-8i : 56-8i]. A byte advances only on byte_valid & byte_ready.
- start in any state other than IDLE is ignored. res_valid outside COLLECT is ignored.

## Timing
Reset values:
- State IDLE; res_ready = 0, byte_valid = 0, byte_out = 0, busy = 0.
- Slice register and all counters cleared.

Cycle behavior:
- start sampled in cycle t: COLLECT and res_ready = 1 from cycle t+1.
- Throughput: one residual per cycle while res_valid stays high. Quantization adds no stall.
- The 20th acceptance in cycle t drops res_ready in cycle t+1. EMIT begins in t+1 with byte_valid = 1 and byte 0 on byte_out.
- Minimum slice latency is 1 + 20 + 8 = 29 cycles from start to the last byte handshake.
- byte_out and byte_valid are registered outputs.
- Once byte_valid is high, byte_out is held stable until the handshake completes.
- Backpressure: byte_ready low holds the current byte indefinitely.
- The handshake on byte 7 in cycle t returns the block to IDLE in t+1. A start in t+1 is accepted.
- Asynchronous reset mid-slice discards the partial slice. No byte of that slice is emitted afterward.

## Structure
Shared package `qoa_pkg`, reused by the decoder, holds:
- RECIP table, QUANT table, and the SCALEFACTOR table (1,7,21,45,84,138,211,304,421,562,731,928,1157,1419,1715,2048).
- Slice width 64 and SLICE_LEN 20.
- State enum.

Sub-module `qoa_quantize`:
- Purely combinational: sf[3:0] and v[16:0] in, code[2:0] out.
- Unit-testable against the software encoder.

## Test plan
- Reset, then start with sf = 0 and 20 residuals of 0 -> bytes 00 00 00 00 00 00 00 00. busy drops one cycle after the last handshake.
- sf = 0, residuals 3, -20, then 18 x 0 -> codes 2, 7 then zeros. Bytes: 05 C0 00 00 00 00 00 00.
- sf = 15, residuals 5000, 1000, then 18 x 0 -> codes 2, 0. Bytes: F4 00 00 00 00 00 00 00.
- res_valid toggled randomly and byte_ready low for 5 cycles mid-EMIT -> identical byte sequence to the unstalled run; byte_out stable while stalled.
- start pulsed during COLLECT with sf = 3 after an sf = 0 start -> ignored; header nibble stays 0.
- rst_n asserted after 10 residuals, then a fresh full slice -> only the fresh slice's 8 bytes appear, and they match the reference model.
